gf22_pad_input_conditioner: RTL and testbench
=============================================

// Module: gf22_pad_input_conditioner
// PURPOSE
// - Sits directly downstream of the GF22 input pad cells and consumes their raw, asynchronous pad_out_o values.
// - Per input bit:
//   - 2-flop synchroniser into clk_i;
//   - programmable debounce / glitch filter;
//   - single-cycle rise/fall event pulses for peripherals and the interrupt controller.
// PARAMETERS
// - NUM_INPUTS  4     number of independent pad inputs conditioned
// - CNT_WIDTH   8     width of debounce counter and debounce_cycles_i
// - RESET_VAL   1'b0  reset value of sync/filter flops, all bits (idle pad level)
// PORTS
// - clk_i              in   1           system clock
// - rst_ni             in   1           asynchronous active-low reset
// - pad_raw_i          in   NUM_INPUTS  raw values from pad cell pad_out_o (asynchronous)
// - filter_en_i        in   NUM_INPUTS  per-bit debounce enable (quasi-static, from config reg)
// - debounce_cycles_i  in   CNT_WIDTH   stable cycles required beyond first mismatch (D), shared by all bits
// - sync_o             out  NUM_INPUTS  synchronised, unfiltered value
// - filt_o             out  NUM_INPUTS  synchronised, debounced value
// - rise_o             out  NUM_INPUTS  1-cycle pulse, filt_o went 0->1
// - fall_o             out  NUM_INPUTS  1-cycle pulse, filt_o went 1->0
// BEHAVIOUR
// - Reset (async assert, sync-free deassert):
//   - both sync stages, filt_o and the edge-detect flop = RESET_VAL;
//   - counters = 0; rise_o = fall_o = 0.
// - Synchroniser: s1 <= pad_raw_i; s2 <= s1; sync_o = s2.
//   - Raw change visible on sync_o 2 clk edges later.
//   - No reset-less flops; no combinational path from pad_raw_i to any output.
// - Filter, per bit i, evaluated each clk_i edge:
//   - filter_en_i[i]=0: filt[i] <= sync[i]; cnt[i] <= 0.
//   - filter_en_i[i]=1, sync[i]==filt[i]: cnt[i] <= 0 (glitch discarded, count restarts).
//   - filter_en_i[i]=1, sync[i]!=filt[i], cnt[i] >= D: filt[i] <= sync[i]; cnt[i] <= 0.
//   - filter_en_i[i]=1, sync[i]!=filt[i], cnt[i] < D: cnt[i] <= cnt[i]+1.
//   - The >= compare handles D lowered mid-count: update on next edge.
//   - cnt never exceeds D before clearing, so no wrap; D = 2^CNT_WIDTH-1 is legal.
// - Latency pad_raw_i -> filt_o:
//   - 3 edges if disabled or D=0;
//   - 3+D edges if enabled and the input is stable for D+1 synchronised cycles.
// - Edge detect: prev[i] <= filt[i] each edge.
//   - rise_o[i] = filt[i] & ~prev[i]; fall_o[i] = ~filt[i] & prev[i].
//   - Pulse high exactly in the first cycle filt_o shows the new value, for one cycle.
// - Toggling filter_en_i:
//   - 1->0 mid-count: filt follows sync next edge, counter cleared.
//   - 0->1: counting starts from 0.
// - Bits are fully independent except the shared D.
//   - Simultaneous events on several bits produce simultaneous pulses.
// - Reset mid-count: counter and filt return to reset values immediately.
//   - No edge pulse is generated by reset or by its release while pad_raw_i == RESET_VAL.
// - Reset release with pad_raw_i != RESET_VAL: rises propagate normally after sync latency.
//   - Example: one rise_o pulse when RESET_VAL=0 and the pad is high.
// TESTING
// - Reset, all inputs low, RESET_VAL=0:
//   - outputs 0 during and after reset;
//   - no rise_o/fall_o for 20 cycles after release.
// - filter_en=0, pad_raw_i[0] 0->1 between edges:
//   - sync_o[0]=1 after 2 edges; filt_o[0]=1 after 3 edges;
//   - rise_o[0] high exactly that one cycle.
// - filter_en=1, D=5, bit1 held high 10 cycles:
//   - filt_o[1]=1 at edge 8; single rise_o[1]; later 1->0 gives single fall_o[1] 8 edges after.
// - filter_en=1, D=5, bit2 glitches high for 4 cycles then low:
//   - filt_o[2] stays 0; no pulses; counter back at 0.
// - D=200 mid-count (cnt=50), D changed to 10:
//   - filt updates next edge.
// - D=200 mid-count (cnt=50), rst_ni asserted instead:
//   - outputs return to RESET_VAL asynchronously; no pulse on release.
// - All 4 bits rise simultaneously, mixed enables (D=3):
//   - disabled bits pulse at edge 3, enabled bits at edge 6.

Source files
------------

// File: rtl/gf22_pad_input_conditioner.sv
// Conditions raw asynchronous pad inputs: 2-flop synchroniser, per-bit debounce filter,
// and single-cycle rise/fall pulses derived from the filtered level.
module gf22_pad_input_conditioner #(
    parameter int   NUM_INPUTS = 4,
    parameter int   CNT_WIDTH  = 8,
    parameter logic RESET_VAL  = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic [NUM_INPUTS-1:0] pad_raw_i,
    input  logic [NUM_INPUTS-1:0] filter_en_i,
    input  logic [CNT_WIDTH-1:0]  debounce_cycles_i,
    output logic [NUM_INPUTS-1:0] sync_o,
    output logic [NUM_INPUTS-1:0] filt_o,
    output logic [NUM_INPUTS-1:0] rise_o,
    output logic [NUM_INPUTS-1:0] fall_o
);

    logic [NUM_INPUTS-1:0]                r_sync1;
    logic [NUM_INPUTS-1:0]                r_sync2;
    logic [NUM_INPUTS-1:0]                r_filt;
    logic [NUM_INPUTS-1:0]                r_prev;
    logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] r_cnt;

    logic [NUM_INPUTS-1:0]                w_filt_nxt;
    logic [NUM_INPUTS-1:0][CNT_WIDTH-1:0] w_cnt_nxt;

    // The >= compare lets a lowered threshold take effect on the very next edge,
    // and guarantees the counter clears before it could ever wrap.
    always_comb begin
        w_filt_nxt = r_filt;
        w_cnt_nxt  = r_cnt;
        for (int i = 0; i < NUM_INPUTS; i++) begin
            if (!filter_en_i[i]) begin
                w_filt_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]  = '0;
            end else if (r_sync2[i] == r_filt[i]) begin
                w_cnt_nxt[i]  = '0;
            end else if (r_cnt[i] >= debounce_cycles_i) begin
                w_filt_nxt[i] = r_sync2[i];
                w_cnt_nxt[i]  = '0;
            end else begin
                w_cnt_nxt[i]  = r_cnt[i] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_sync1 <= {NUM_INPUTS{RESET_VAL}};
            r_sync2 <= {NUM_INPUTS{RESET_VAL}};
            r_filt  <= {NUM_INPUTS{RESET_VAL}};
            r_prev  <= {NUM_INPUTS{RESET_VAL}};
            r_cnt   <= '0;
        end else begin
            r_sync1 <= pad_raw_i;
            r_sync2 <= r_sync1;
            r_filt  <= w_filt_nxt;
            r_prev  <= r_filt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    assign sync_o = r_sync2;
    assign filt_o = r_filt;
    assign rise_o = r_filt & ~r_prev;
    assign fall_o = ~r_filt & r_prev;

endmodule

// File: tb/tb_gf22_pad_input_conditioner.sv
// Scoreboard bench: stimulus pushes expected pulses and level probes keyed by clock
// edge count; monitors pop and compare independently of the stimulus thread.
module tb_gf22_pad_input_conditioner;

    logic       clk = 1'b0;
    logic       rst_ni = 1'b1;
    logic [3:0] pad = '0;
    logic [3:0] en = '0;
    logic [7:0] dcyc = '0;
    logic [3:0] sync_o, filt_o, rise_o, fall_o;

    int cyc = 0;
    int n_total = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        logic [3:0] mask;
        logic [3:0] sync;
        logic [3:0] filt;
        logic [3:0] rise;
        logic [3:0] fall;
    } probe_t;

    typedef struct {
        int         cyc;
        logic [3:0] rise;
        logic [3:0] fall;
    } ev_t;

    probe_t probe_q[$];
    ev_t    ev_q[$];

    gf22_pad_input_conditioner #(
        .NUM_INPUTS(4),
        .CNT_WIDTH (8),
        .RESET_VAL (1'b0)
    ) dut (
        .clk_i            (clk),
        .rst_ni           (rst_ni),
        .pad_raw_i        (pad),
        .filter_en_i      (en),
        .debounce_cycles_i(dcyc),
        .sync_o           (sync_o),
        .filt_o           (filt_o),
        .rise_o           (rise_o),
        .fall_o           (fall_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic probe(input int c, input logic [3:0] m, input logic [3:0] s,
                         input logic [3:0] f, input logic [3:0] r, input logic [3:0] fl);
        probe_t p;
        p.cyc = c; p.mask = m; p.sync = s; p.filt = f; p.rise = r; p.fall = fl;
        probe_q.push_back(p);
    endtask

    task automatic expect_ev(input int c, input logic [3:0] r, input logic [3:0] fl);
        ev_t e;
        e.cyc = c; e.rise = r; e.fall = fl;
        ev_q.push_back(e);
    endtask

    task automatic quiet(input int first, input int n);
        for (int c = first; c < first + n; c++) probe(c, 4'b1111, 4'b0, 4'b0, 4'b0, 4'b0);
    endtask

    // Level/pulse probe checker and pulse scoreboard.
    always @(negedge clk) begin
        probe_t p;
        ev_t    e;
        while (probe_q.size() != 0 && probe_q[0].cyc <= cyc) begin
            p = probe_q.pop_front();
            n_total++;
            if (p.cyc != cyc || ((sync_o ^ p.sync) & p.mask) != 0 ||
                ((filt_o ^ p.filt) & p.mask) != 0 || ((rise_o ^ p.rise) & p.mask) != 0 ||
                ((fall_o ^ p.fall) & p.mask) != 0) begin
                n_bad++;
                $display("FAIL probe edge=%0d at=%0d mask=%b sync=%b want %b filt=%b want %b rise=%b want %b fall=%b want %b",
                         p.cyc, cyc, p.mask, sync_o, p.sync, filt_o, p.filt, rise_o, p.rise, fall_o, p.fall);
            end
        end
        while (ev_q.size() != 0 && ev_q[0].cyc < cyc) begin
            e = ev_q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL missed_pulse edge=%0d got none, want rise=%b fall=%b", e.cyc, e.rise, e.fall);
        end
        if ((rise_o | fall_o) != 4'b0) begin
            n_total++;
            if (ev_q.size() != 0 && ev_q[0].cyc == cyc) begin
                e = ev_q.pop_front();
                if (rise_o != e.rise || fall_o != e.fall) begin
                    n_bad++;
                    $display("FAIL pulse edge=%0d rise=%b want %b fall=%b want %b",
                             cyc, rise_o, e.rise, fall_o, e.fall);
                end
            end else begin
                n_bad++;
                $display("FAIL unexpected_pulse edge=%0d rise=%b fall=%b want none", cyc, rise_o, fall_o);
            end
        end
    end

    // Reset must clear every output asynchronously, without waiting for a clock edge.
    always @(negedge rst_ni) begin
        #1;
        n_total++;
        if ({sync_o, filt_o, rise_o, fall_o} != 16'h0) begin
            n_bad++;
            $display("FAIL async_reset sync=%b filt=%b rise=%b fall=%b want all 0",
                     sync_o, filt_o, rise_o, fall_o);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at edge=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int k, k2;
        #1 rst_ni = 1'b0;
        tick(1);
        quiet(cyc + 1, 3);
        tick(3);
        rst_ni = 1'b1;
        quiet(cyc + 1, 20);
        tick(20);

        // Unfiltered rise then fall on bit 0
        k = cyc;
        probe(k + 1, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 2, 4'b1111, 4'b0001, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 3, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        probe(k + 4, 4'b1111, 4'b0001, 4'b0001, 4'b0000, 4'b0000);
        expect_ev(k + 3, 4'b0001, 4'b0000);
        pad[0] = 1'b1;
        tick(6);
        k = cyc;
        expect_ev(k + 3, 4'b0000, 4'b0001);
        probe(k + 3, 4'b1111, 4'b0000, 4'b0000, 4'b0000, 4'b0001);
        pad[0] = 1'b0;
        tick(6);

        // Debounced bit 1, D=5, held high 10 cycles
        en = 4'b0010; dcyc = 8'd5;
        tick(2);
        k = cyc;
        expect_ev(k + 8, 4'b0010, 4'b0000);
        expect_ev(k + 18, 4'b0000, 4'b0010);
        probe(k + 7, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 8, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        probe(k + 17, 4'b0010, 4'b0000, 4'b0010, 4'b0000, 4'b0000);
        probe(k + 18, 4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0010);
        pad[1] = 1'b1;
        tick(10);
        pad[1] = 1'b0;
        tick(12);

        // Disabling the filter mid-count releases the level on the next edge
        k = cyc;
        expect_ev(k + 5, 4'b0010, 4'b0000);
        probe(k + 4, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 5, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000);
        pad[1] = 1'b1;
        tick(4);
        en = 4'b0000;
        tick(4);
        k2 = cyc;
        expect_ev(k2 + 3, 4'b0000, 4'b0010);
        pad[1] = 1'b0;
        tick(6);

        // Glitch on bit 2 shorter than D, then a clean rise timed from a fresh count
        en = 4'b0100; dcyc = 8'd5;
        tick(2);
        k = cyc;
        for (int c = k + 2; c <= k + 12; c++)
            probe(c, 4'b0100, (c <= k + 5) ? 4'b0100 : 4'b0000, 4'b0000, 4'b0000, 4'b0000);
        pad[2] = 1'b1;
        tick(4);
        pad[2] = 1'b0;
        tick(8);
        k = cyc;
        expect_ev(k + 8, 4'b0100, 4'b0000);
        probe(k + 7, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 8, 4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000);
        pad[2] = 1'b1;
        tick(12);
        k = cyc;
        expect_ev(k + 8, 4'b0000, 4'b0100);
        pad[2] = 1'b0;
        tick(10);

        // D=200 lowered to 10 with the counter at 50
        en = 4'b1000; dcyc = 8'd200;
        tick(2);
        k = cyc;
        expect_ev(k + 53, 4'b1000, 4'b0000);
        probe(k + 52, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 4'b0000);
        probe(k + 53, 4'b1000, 4'b1000, 4'b1000, 4'b1000, 4'b0000);
        pad[3] = 1'b1;
        tick(52);
        dcyc = 8'd10;
        tick(4);
        k2 = cyc;
        expect_ev(k2 + 3, 4'b0000, 4'b1000);
        en = 4'b0000;
        pad[3] = 1'b0;
        tick(6);

        // Reset asserted with the counter at 50; released with pads low
        en = 4'b1000; dcyc = 8'd200;
        tick(2);
        pad[3] = 1'b1;
        tick(52);
        rst_ni = 1'b0;
        pad[3] = 1'b0;
        tick(3);
        rst_ni = 1'b1;
        quiet(cyc + 1, 20);
        tick(20);

        // Release from reset with the pad already high gives one rise
        en = 4'b0000;
        rst_ni = 1'b0;
        pad[0] = 1'b1;
        tick(3);
        expect_ev(cyc + 3, 4'b0001, 4'b0000);
        probe(cyc + 3, 4'b1111, 4'b0001, 4'b0001, 4'b0001, 4'b0000);
        rst_ni = 1'b1;
        tick(6);
        k = cyc;
        expect_ev(k + 3, 4'b0000, 4'b0001);
        pad[0] = 1'b0;
        tick(6);

        // All bits together, bits 0/2 filtered with D=3
        en = 4'b0101; dcyc = 8'd3;
        tick(2);
        k = cyc;
        expect_ev(k + 3, 4'b1010, 4'b0000);
        expect_ev(k + 6, 4'b0101, 4'b0000);
        probe(k + 3, 4'b1111, 4'b1111, 4'b1010, 4'b1010, 4'b0000);
        probe(k + 6, 4'b1111, 4'b1111, 4'b1111, 4'b0101, 4'b0000);
        pad = 4'b1111;
        tick(10);
        k = cyc;
        expect_ev(k + 3, 4'b0000, 4'b1010);
        expect_ev(k + 6, 4'b0000, 4'b0101);
        pad = 4'b0000;
        tick(10);

        tick(5);
        while (probe_q.size() != 0) begin
            probe_t p;
            p = probe_q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL probe_unchecked edge=%0d got never sampled, want sampled", p.cyc);
        end
        while (ev_q.size() != 0) begin
            ev_t e;
            e = ev_q.pop_front();
            n_total++;
            n_bad++;
            $display("FAIL pulse_never_seen edge=%0d got none, want rise=%b fall=%b", e.cyc, e.rise, e.fall);
        end
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
